uart_mvm: RTL and testbench

//  UART-attached matrix-vector multiplier for a TinyTapeout tile. Host streams an NxN signed

---
 rtl/uart_mvm_pkg.sv | 29 ++
 rtl/uart_mvm_rx.sv | 112 +++++++++++
 rtl/uart_mvm.sv | 190 +++++++++++++++++++
 tb/tb_uart_mvm.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_mvm_pkg.sv
// Shared types, widths and helpers for the UART matrix-vector multiplier.
// Latency: none (types, constants and a combinational function only).
// Backpressure: none.
package uart_mvm_pkg;

   typedef enum logic [2:0] {
      LOAD    = 3'd0,
      COMPUTE = 3'd1,
      SEND    = 3'd2
   } state_t;

   localparam int ELEM_W = 8;
   localparam int ACC_W  = 18;
   localparam int Y_W    = 16;

   localparam logic signed [ACC_W-1:0] Y_MAX = 18'sd32767;
   localparam logic signed [ACC_W-1:0] Y_MIN = -18'sd32768;

   // Clamp an accumulator value into the int16 range.
   function automatic logic [Y_W-1:0] sat16(input logic signed [ACC_W-1:0] a);
      if (a > Y_MAX)
         return 16'h7FFF;
      else if (a < Y_MIN)
         return 16'h8000;
      else
         return a[Y_W-1:0];
   endfunction

endpackage

// File: rtl/uart_mvm_rx.sv
// 2-FF synchronizer plus 8N1 UART receiver with mid-bit sampling and glitch rejection.
// Latency: valid pulses about half a bit time into the stop bit (plus 2 sync cycles).
// Backpressure: none; each byte is presented for one cycle and must be taken then.
module uart_rx #(
   parameter int CLKS_PER_BIT = 87
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       rx,
   output logic [7:0] data,
   output logic       valid,
   output logic       frame_err,
   output logic       active
);

   localparam int CW   = $clog2(CLKS_PER_BIT);
   localparam int HALF = CLKS_PER_BIT / 2;

   typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

   rx_state_t       state, state_nxt;
   logic            rx_meta, rx_sync, rx_prev;
   logic [CW-1:0]   cnt;
   logic [2:0]      bit_idx;
   logic [7:0]      shreg;
   logic            tick_half, tick_full;

   assign tick_half = (cnt == CW'(HALF - 1));
   assign tick_full = (cnt == CW'(CLKS_PER_BIT - 1));
   assign active    = (state != R_IDLE);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= R_IDLE;
      else
         state <= state_nxt;
   end

   // Next-state: falling edge starts a frame, a high start bit at mid-bit aborts it.
   always_comb begin
      state_nxt = state;
      if (clr) begin
         state_nxt = R_IDLE;
      end else begin
         case (state)
            R_IDLE:  if (rx_prev && !rx_sync) state_nxt = R_START;
            R_START: if (tick_half) state_nxt = rx_sync ? R_IDLE : R_DATA;
            R_DATA:  if (tick_full && bit_idx == 3'd7) state_nxt = R_STOP;
            R_STOP:  if (tick_full) state_nxt = R_IDLE;
            default: state_nxt = R_IDLE;
         endcase
      end
   end

   // Synchronizer, bit timer, shift register and result pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta   <= 1'b1;
         rx_sync   <= 1'b1;
         rx_prev   <= 1'b1;
         cnt       <= '0;
         bit_idx   <= '0;
         shreg     <= '0;
         data      <= '0;
         valid     <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         rx_meta   <= rx;
         rx_sync   <= rx_meta;
         rx_prev   <= rx_sync;
         valid     <= 1'b0;
         frame_err <= 1'b0;
         if (clr) begin
            cnt     <= '0;
            bit_idx <= '0;
         end else begin
            case (state)
               R_START: cnt <= tick_half ? '0 : cnt + CW'(1);
               R_DATA: begin
                  if (tick_full) begin
                     cnt     <= '0;
                     shreg   <= {rx_sync, shreg[7:1]};
                     bit_idx <= bit_idx + 3'd1;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
               R_STOP: begin
                  if (tick_full) begin
                     cnt <= '0;
                     if (rx_sync) begin
                        data  <= shreg;
                        valid <= 1'b1;
                     end else begin
                        frame_err <= 1'b1;
                     end
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
               default: begin
                  cnt     <= '0;
                  bit_idx <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: rtl/uart_mvm.sv
// UART-attached NxN int8 matrix-vector multiplier (y = A*x, int16 saturated results).
// Latency: N*N compute cycles after the last payload byte, then 2N back-to-back TX bytes.
// Backpressure: none; RX bytes arriving while busy (COMPUTE/SEND) are dropped.
module uart_mvm
   import uart_mvm_pkg::*;
#(
   parameter int N            = 4,
   parameter int CLKS_PER_BIT = 87
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ena,
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   localparam int TOTAL = N * N + N;
   localparam int BC_W  = $clog2(TOTAL + 1);
   localparam int RC_W  = $clog2(N);
   localparam int NB    = 2 * N;
   localparam int TI_W  = $clog2(NB + 1);
   localparam int CW    = $clog2(CLKS_PER_BIT);

   state_t                     state, state_nxt;
   logic                       soft_clr;
   logic [7:0]                 rx_data;
   logic                       rx_valid, rx_ferr, rx_active;
   logic [BC_W-1:0]            byte_cnt;
   logic [ELEM_W-1:0]          mem [TOTAL];
   logic [RC_W-1:0]            ri, rj;
   logic [BC_W-1:0]            a_idx, x_idx;
   logic signed [2*ELEM_W-1:0] prod;
   logic signed [ACC_W-1:0]    acc, acc_sum;
   logic [Y_W-1:0]             y [N];
   logic                       done, frame_err, busy, tx;
   logic [9:0]                 tx_shift;
   logic [3:0]                 tx_bits;
   logic [CW-1:0]              tx_cnt;
   logic [TI_W-1:0]            tx_idx;
   logic [RC_W-1:0]            y_sel;
   logic [7:0]                 tx_byte;
   logic                       load_last, mac_last, tx_bit_end, send_last;
   logic                       unused_ok;

   assign soft_clr  = ui_in[0];
   assign unused_ok = &{1'b0, ena, ui_in[7:4], ui_in[2:1], uio_in};

   uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .clk       (clk),
      .rst       (rst),
      .clr       (soft_clr),
      .rx        (ui_in[3]),
      .data      (rx_data),
      .valid     (rx_valid),
      .frame_err (rx_ferr),
      .active    (rx_active)
   );

   assign a_idx   = BC_W'(ri) * BC_W'(N) + BC_W'(rj);
   assign x_idx   = BC_W'(N * N) + BC_W'(rj);
   assign prod    = $signed(mem[a_idx]) * $signed(mem[x_idx]);
   assign acc_sum = acc + {{(ACC_W - 2*ELEM_W){prod[2*ELEM_W-1]}}, prod};

   assign y_sel   = tx_idx[RC_W:1];
   assign tx_byte = tx_idx[0] ? y[y_sel][15:8] : y[y_sel][7:0];

   assign load_last  = (state == LOAD) && rx_valid && (byte_cnt == BC_W'(TOTAL - 1));
   assign mac_last   = (state == COMPUTE) && (ri == RC_W'(N - 1)) && (rj == RC_W'(N - 1));
   assign tx_bit_end = (tx_bits != 4'd0) && (tx_cnt == CW'(CLKS_PER_BIT - 1));
   assign send_last  = (state == SEND) && tx_bit_end && (tx_bits == 4'd1) && (tx_idx == TI_W'(NB));

   assign busy    = (state != LOAD);
   assign tx      = tx_shift[0] | soft_clr;
   assign uo_out  = {state, tx, rx_active, frame_err, done, busy};
   assign uio_out = '0;
   assign uio_oe  = '0;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= LOAD;
      else
         state <= state_nxt;
   end

   // Next-state: payload complete -> compute -> send -> back to load.
   always_comb begin
      state_nxt = state;
      if (soft_clr) begin
         state_nxt = LOAD;
      end else begin
         case (state)
            LOAD:    if (load_last) state_nxt = COMPUTE;
            COMPUTE: if (mac_last)  state_nxt = SEND;
            SEND:    if (send_last) state_nxt = LOAD;
            default: state_nxt = LOAD;
         endcase
      end
   end

   // Payload storage, byte counter and sticky status flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < TOTAL; i++) mem[i] <= '0;
         byte_cnt  <= '0;
         done      <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         if (rx_ferr) frame_err <= 1'b1;
         if (soft_clr) begin
            byte_cnt  <= '0;
            done      <= 1'b0;
            frame_err <= 1'b0;
         end else begin
            if (state == LOAD && rx_valid) begin
               mem[byte_cnt] <= rx_data;
               byte_cnt      <= byte_cnt + BC_W'(1);
               done          <= 1'b0;
            end
            if (send_last) begin
               done     <= 1'b1;
               byte_cnt <= '0;
            end
         end
      end
   end

   // One MAC per cycle; saturate and store at the end of each row.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ri  <= '0;
         rj  <= '0;
         acc <= '0;
         for (int i = 0; i < N; i++) y[i] <= '0;
      end else if (soft_clr) begin
         ri  <= '0;
         rj  <= '0;
         acc <= '0;
      end else if (state == COMPUTE) begin
         if (rj == RC_W'(N - 1)) begin
            y[ri] <= sat16(acc_sum);
            acc   <= '0;
            rj    <= '0;
            ri    <= (ri == RC_W'(N - 1)) ? '0 : ri + RC_W'(1);
         end else begin
            acc <= acc_sum;
            rj  <= rj + RC_W'(1);
         end
      end
   end

   // Transmitter: frames are chained so the next start bit follows the stop bit directly.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_shift <= '1;
         tx_bits  <= '0;
         tx_cnt   <= '0;
         tx_idx   <= '0;
      end else if (soft_clr) begin
         tx_shift <= '1;
         tx_bits  <= '0;
         tx_cnt   <= '0;
         tx_idx   <= '0;
      end else if (mac_last) begin
         tx_shift <= {1'b1, tx_byte, 1'b0};
         tx_bits  <= 4'd10;
         tx_cnt   <= '0;
         tx_idx   <= tx_idx + TI_W'(1);
      end else if (tx_bits != 4'd0) begin
         if (tx_bit_end) begin
            tx_cnt <= '0;
            if (tx_bits == 4'd1 && tx_idx != TI_W'(NB)) begin
               tx_shift <= {1'b1, tx_byte, 1'b0};
               tx_bits  <= 4'd10;
               tx_idx   <= tx_idx + TI_W'(1);
            end else begin
               tx_shift <= {1'b1, tx_shift[9:1]};
               tx_bits  <= tx_bits - 4'd1;
               if (tx_bits == 4'd1) tx_idx <= '0;
            end
         end else begin
            tx_cnt <= tx_cnt + CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_uart_mvm.sv
module tb_uart_mvm;

   localparam int CPB = 8;
   localparam int N   = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ena = 1'b1;
   logic       rx_line = 1'b1;
   logic       clr_in = 1'b0;
   logic [7:0] ui_in;
   logic [7:0] uo_out, uio_out, uio_oe;
   logic [7:0] uio_in = 8'h00;

   assign ui_in = {4'b0000, rx_line, 2'b00, clr_in};

   uart_mvm #(.N(N), .CLKS_PER_BIT(CPB)) dut (
      .clk     (clk),
      .rst     (rst),
      .ena     (ena),
      .ui_in   (ui_in),
      .uo_out  (uo_out),
      .uio_in  (uio_in),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   always #5 clk = ~clk;

   int         n_checks = 0;
   int         n_errors = 0;
   logic [7:0] exp_q[$];
   logic       mon_en = 1'b1;
   logic [7:0] pay [20];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      rx_line = 1'b0;
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         rx_line = b[i];
         tick(CPB);
      end
      rx_line = stop_bit;
      tick(CPB);
      rx_line = 1'b1;
      tick(4);
   endtask

   task automatic send_payload();
      for (int i = 0; i < 20; i++) send_byte(pay[i], 1'b1);
   endtask

   task automatic clear_pay();
      for (int i = 0; i < 20; i++) pay[i] = 8'h00;
   endtask

   task automatic set_identity(input logic [7:0] d);
      clear_pay();
      for (int i = 0; i < N; i++) pay[i*N+i] = d;
   endtask

   task automatic set_x(input logic [31:0] xv);
      for (int i = 0; i < N; i++) pay[16+i] = xv[31-8*i -: 8];
   endtask

   task automatic expect8(input logic [63:0] bytes);
      for (int i = 0; i < 8; i++) exp_q.push_back(bytes[63-8*i -: 8]);
   endtask

   task automatic wait_done(input string name);
      int k;
      k = 0;
      while (uo_out[1] !== 1'b1 && k < 5000) begin
         tick(1);
         k++;
      end
      if (k >= 5000) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s_timeout: done not seen within 5000 cycles", name);
      end
   endtask

   task automatic wait_send(input string name);
      int k;
      k = 0;
      while (uo_out[7:5] !== 3'd2 && k < 5000) begin
         tick(1);
         k++;
      end
      if (k >= 5000) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s_timeout: SEND state not seen within 5000 cycles", name);
      end
   endtask

   task automatic finish_payload(input string name);
      wait_done(name);
      tick(2);
      chk({name, "_status"}, {24'h0, uo_out & 8'hEB}, 32'h02);
      chk({name, "_q_empty"}, exp_q.size(), 0);
   endtask

   // TX monitor: decode each frame on uo_out[4] and compare against the scoreboard.
   initial begin
      logic [7:0] b;
      logic       st, sp;
      forever begin
         @(negedge uo_out[4]);
         repeat (CPB/2) @(posedge clk);
         #1 st = uo_out[4];
         for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(posedge clk);
            #1 b[i] = uo_out[4];
         end
         repeat (CPB) @(posedge clk);
         #1 sp = uo_out[4];
         if (mon_en) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_errors++;
               $display("FAIL tx_unexpected: got byte %h with no byte expected", b);
            end else begin
               logic [7:0] e;
               e = exp_q.pop_front();
               if (b !== e || st !== 1'b0 || sp !== 1'b1) begin
                  n_errors++;
                  $display("FAIL tx_byte: got %h start %b stop %b expected %h start 0 stop 1",
                           b, st, sp, e);
               end
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      tick(5);
      chk("reset_uo_out", {24'h0, uo_out}, 32'h10);
      chk("reset_uio_out", {24'h0, uio_out}, 32'h00);
      chk("reset_uio_oe", {24'h0, uio_oe}, 32'h00);
      rst = 1'b0;
      tick(5);

      // Identity matrix, x = [1,2,3,4].
      set_identity(8'h01);
      set_x(32'h01020304);
      expect8(64'h01_00_02_00_03_00_04_00);
      send_payload();
      finish_payload("identity");

      // Positive saturation: every product 16384, row sum 65536.
      for (int i = 0; i < 20; i++) pay[i] = 8'h80;
      expect8(64'hFF_7F_FF_7F_FF_7F_FF_7F);
      send_payload();
      finish_payload("sat_pos");

      // 127 * -128 = -16256 = 0xC080 in every row.
      clear_pay();
      for (int i = 0; i < N; i++) pay[i*N] = 8'h7F;
      pay[16] = 8'h80;
      expect8(64'h80_C0_80_C0_80_C0_80_C0);
      send_payload();
      finish_payload("neg_prod");

      // Framing error: byte discarded, flag sticky, done untouched.
      send_byte(8'h55, 1'b0);
      tick(20);
      chk("ferr_set", {31'h0, uo_out[2]}, 32'h1);
      chk("ferr_done_kept", {31'h0, uo_out[1]}, 32'h1);
      set_identity(8'h01);
      set_x(32'h01020304);
      expect8(64'h01_00_02_00_03_00_04_00);
      send_payload();
      wait_done("after_ferr");
      tick(2);
      chk("after_ferr_status", {24'h0, uo_out}, 32'h16);
      chk("after_ferr_q_empty", exp_q.size(), 0);

      // Partial payload then soft clear; the new payload must start at byte 0.
      for (int i = 0; i < 10; i++) send_byte(8'h33, 1'b1);
      clr_in = 1'b1;
      tick(1);
      clr_in = 1'b0;
      tick(2);
      chk("soft_clr_status", {24'h0, uo_out}, 32'h10);
      set_identity(8'h02);
      set_x(32'h01020304);
      expect8(64'h02_00_04_00_06_00_08_00);
      send_payload();
      finish_payload("after_clr");

      // RX bytes during SEND must be dropped.
      set_identity(8'h01);
      set_x(32'hFF02FD04);
      expect8(64'hFF_FF_02_00_FD_FF_04_00);
      send_payload();
      wait_send("inject");
      send_byte(8'hAA, 1'b1);
      send_byte(8'h01, 1'b1);
      send_byte(8'h02, 1'b1);
      finish_payload("inject");
      set_identity(8'h01);
      set_x(32'h01020304);
      expect8(64'h01_00_02_00_03_00_04_00);
      send_payload();
      finish_payload("post_inject");

      // Reset in the middle of a transmitted byte.
      mon_en = 1'b0;
      send_payload();
      wait_send("rst_mid");
      tick(100);
      rst = 1'b1;
      #1;
      chk("rst_mid_uo_out", {24'h0, uo_out}, 32'h10);
      tick(3);
      rst = 1'b0;
      tick(120);
      mon_en = 1'b1;

      // Quarter-bit glitch on idle RX.
      rx_line = 1'b0;
      tick(CPB/4);
      rx_line = 1'b1;
      tick(40);
      chk("glitch_status", {24'h0, uo_out}, 32'h10);
      clear_pay();
      for (int i = 0; i < N; i++)
         for (int j = 0; j <= i; j++) pay[i*N+j] = 8'h01;
      set_x(32'h01020304);
      expect8(64'h01_00_03_00_06_00_0A_00);
      send_payload();
      finish_payload("after_glitch");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
